// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner and its capture block.
package tt_scan_pkg;

   localparam int unsigned TT_WIDTH = 16;
   localparam int unsigned TT_IDX_W = 4;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scanState_t;

   // Vector presented to the function under test.
   typedef struct packed {
      logic a;
      logic b;
      logic c;
      logic d;
   } ttVector_t;

   // With three swept inputs, idx[2:0] drives a..c and d is tied low.
   function automatic ttVector_t mapVector(input logic [TT_IDX_W-1:0] idx,
                                           input int unsigned numVars);
      ttVector_t v;
      if (numVars == 3) v = ttVector_t'({idx[2:0], 1'b0});
      else              v = ttVector_t'(idx);
      return v;
   endfunction

endpackage

// File: rtl/tt_scan_capture.sv
// Truth-table capture registers plus sticky first-mismatch tracking.
// With TT_SCAN_EXPECT_EN, the next-state tables are exported for the end-of-scan compare.
module tt_scan_capture
   import tt_scan_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                sampleEn,
   input  logic [TT_IDX_W-1:0] idx,
   input  logic                fmin,
   input  logic                fmax,
   output logic [TT_WIDTH-1:0] ttMin,
   output logic [TT_WIDTH-1:0] ttMax,
   output logic                mismatch,
   output logic [TT_IDX_W-1:0] firstMismatchIdx
`ifdef TT_SCAN_EXPECT_EN
   ,
   output logic [TT_WIDTH-1:0] ttMinNext_c,
   output logic [TT_WIDTH-1:0] ttMaxNext_c
`endif
);

   logic [TT_WIDTH-1:0] ttMinNxt;
   logic [TT_WIDTH-1:0] ttMaxNxt;

   // Tables with the current sample merged in.
   always_comb begin
      ttMinNxt = ttMin;
      ttMaxNxt = ttMax;
      if (sampleEn) begin
         ttMinNxt[idx] = fmin;
         ttMaxNxt[idx] = fmax;
      end
   end

`ifdef TT_SCAN_EXPECT_EN
   assign ttMinNext_c = ttMinNxt;
   assign ttMaxNext_c = ttMaxNxt;
`endif

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ttMin            <= '0;
         ttMax            <= '0;
         mismatch         <= 1'b0;
         firstMismatchIdx <= '0;
      end else begin
         ttMin <= ttMinNxt;
         ttMax <= ttMaxNxt;
         // Only the lowest differing index is kept.
         if (sampleEn && (fmin != fmax) && !mismatch) begin
            mismatch         <= 1'b1;
            firstMismatchIdx <= idx;
         end
      end
   end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all input vectors of a 3/4-input function and captures SOP/POS truth tables.
// Optional TT_SCAN_EXPECT_EN adds a reference table input and an expect_fail flag.
module truth_table_scanner
   import tt_scan_pkg::*;
#(
   parameter int unsigned NUM_VARS      = 4,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                a,
   output logic                b,
   output logic                c,
   output logic                d,
   input  logic                fmin_i,
   input  logic                fmax_i,
   output logic                busy,
   output logic                done,
   output logic [TT_WIDTH-1:0] tt_min,
   output logic [TT_WIDTH-1:0] tt_max,
   output logic                mismatch,
   output logic [TT_IDX_W-1:0] first_mismatch_idx
`ifdef TT_SCAN_EXPECT_EN
   ,
   input  logic [TT_WIDTH-1:0] expected,
   output logic                expect_fail
`endif
);

   localparam logic [TT_IDX_W-1:0] LAST_IDX    = TT_IDX_W'((32'd1 << NUM_VARS) - 32'd1);
   localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'd1);

   scanState_t          state, nextState;
   logic [TT_IDX_W-1:0] idx, nextIdx;
   logic [CNT_W-1:0]    settleCnt, nextCnt;
   logic                clearTt;
   logic                sampleEn;
   logic                busyNext;
   ttVector_t           vecQ;

   // Next-state, index and settle-counter logic.
   always_comb begin
      nextState = state;
      nextIdx   = idx;
      nextCnt   = settleCnt;
      clearTt   = 1'b0;
      sampleEn  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               clearTt   = 1'b1;
               nextIdx   = '0;
               nextCnt   = '0;
               nextState = DRIVE;
            end
         end
         DRIVE: begin
            if (settleCnt == SETTLE_LAST) begin
               nextCnt   = '0;
               nextState = SAMPLE;
            end else begin
               nextCnt = settleCnt + CNT_W'(1);
            end
         end
         SAMPLE: begin
            sampleEn = 1'b1;
            nextCnt  = '0;
            if (idx == LAST_IDX) begin
               nextState = DONE;
            end else begin
               nextIdx   = idx + TT_IDX_W'(1);
               nextState = DRIVE;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign busyNext = (nextState == DRIVE) || (nextState == SAMPLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         settleCnt <= '0;
         vecQ      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         idx       <= nextIdx;
         settleCnt <= nextCnt;
         vecQ      <= busyNext ? mapVector(nextIdx, NUM_VARS) : '0;
         busy      <= busyNext;
         done      <= (nextState == DONE);
      end
   end

   assign a = vecQ.a;
   assign b = vecQ.b;
   assign c = vecQ.c;
   assign d = vecQ.d;

`ifdef TT_SCAN_EXPECT_EN
   localparam logic [TT_WIDTH-1:0] VEC_MASK =
      TT_WIDTH'((32'd1 << (32'd1 << NUM_VARS)) - 32'd1);

   logic [TT_WIDTH-1:0] ttMinNext;
   logic [TT_WIDTH-1:0] ttMaxNext;
`endif

   tt_scan_capture uCapture (
      .clk              (clk),
      .rst              (rst),
      .clear            (clearTt),
      .sampleEn         (sampleEn),
      .idx              (idx),
      .fmin             (fmin_i),
      .fmax             (fmax_i),
      .ttMin            (tt_min),
      .ttMax            (tt_max),
      .mismatch         (mismatch),
      .firstMismatchIdx (first_mismatch_idx)
`ifdef TT_SCAN_EXPECT_EN
      ,
      .ttMinNext_c      (ttMinNext),
      .ttMaxNext_c      (ttMaxNext)
`endif
   );

`ifdef TT_SCAN_EXPECT_EN
   // Evaluated on the last sample so the verdict is valid during DONE.
   always_ff @(posedge clk) begin
      if (rst || clearTt) begin
         expect_fail <= 1'b0;
      end else if (sampleEn && (nextState == DONE)) begin
         expect_fail <= (|((ttMinNext ^ expected) & VEC_MASK)) |
                        (|((ttMaxNext ^ expected) & VEC_MASK));
      end
   end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: one 3-variable and one 4-variable scanner, results checked on done.
module tb_truth_table_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 3-variable instance, SETTLE_CYCLES=1
   logic rst3, start3, a3, b3, c3, d3, fmin3, fmax3, busy3, done3, mis3;
   logic [15:0] ttMin3, ttMax3;
   logic [3:0]  first3;
   // 4-variable instance, SETTLE_CYCLES=2
   logic rst4, start4, a4, b4, c4, d4, fmin4, fmax4, busy4, done4, mis4;
   logic [15:0] ttMin4, ttMax4;
   logic [3:0]  first4;
   logic [3:0]  vec4;
   int          mode4;

`ifdef TT_SCAN_EXPECT_EN
   logic [15:0] expRef3, expRef4;
   logic        expFail3, expFail4;
`endif

   assign fmin3 = (!a3 && !b3) || (!b3 && c3) || (b3 && !c3);
   assign fmax3 = fmin3;

   // a^d is already 1 at idx 5: mode 1 forces 1 there (no difference), mode 2 flips it.
   assign vec4  = {a4, b4, c4, d4};
   assign fmin4 = a4 ^ d4;
   assign fmax4 = (mode4 == 1 && vec4 == 4'd5) ? 1'b1 :
                  (mode4 == 2 && vec4 == 4'd5) ? ~fmin4 : fmin4;

   truth_table_scanner #(.NUM_VARS(3), .SETTLE_CYCLES(1)) dut3 (
      .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3), .c(c3), .d(d3),
      .fmin_i(fmin3), .fmax_i(fmax3), .busy(busy3), .done(done3),
      .tt_min(ttMin3), .tt_max(ttMax3), .mismatch(mis3), .first_mismatch_idx(first3)
`ifdef TT_SCAN_EXPECT_EN
      , .expected(expRef3), .expect_fail(expFail3)
`endif
   );

   truth_table_scanner #(.NUM_VARS(4), .SETTLE_CYCLES(2)) dut4 (
      .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .c(c4), .d(d4),
      .fmin_i(fmin4), .fmax_i(fmax4), .busy(busy4), .done(done4),
      .tt_min(ttMin4), .tt_max(ttMax4), .mismatch(mis4), .first_mismatch_idx(first4)
`ifdef TT_SCAN_EXPECT_EN
      , .expected(expRef4), .expect_fail(expFail4)
`endif
   );

   typedef struct {
      logic [15:0] ttMin;
      logic [15:0] ttMax;
      logic        mis;
      logic [3:0]  first;
      int          doneCyc;
      logic        expFail;
   } exp_t;

   exp_t q3[$];
   exp_t q4[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic compareResult(input string tag, input exp_t e, input logic [15:0] mn,
                                input logic [15:0] mx, input logic ms, input logic [3:0] fi);
      check({tag, "_ttMin"}, 32'(mn), 32'(e.ttMin));
      check({tag, "_ttMax"}, 32'(mx), 32'(e.ttMax));
      check({tag, "_mismatch"}, 32'(ms), 32'(e.mis));
      check({tag, "_firstIdx"}, 32'(fi), 32'(e.first));
      check({tag, "_doneCycle"}, 32'(cyc), 32'(e.doneCyc));
   endtask

   // Queue the expected result, then pulse start for one cycle.
   task automatic startScan3(input logic [15:0] tt, input logic [15:0] ref3, input logic ef);
      exp_t e;
      e.ttMin = tt; e.ttMax = tt; e.mis = 1'b0; e.first = 4'd0;
      e.doneCyc = cyc + 1 + 16; e.expFail = ef;
`ifdef TT_SCAN_EXPECT_EN
      expRef3 = ref3;
`endif
      q3.push_back(e);
      start3 = 1'b1; tick(1); start3 = 1'b0;
   endtask

   task automatic startScan4(input logic [15:0] mn, input logic [15:0] mx, input logic ms,
                             input logic [3:0] fi, input logic ef);
      exp_t e;
      e.ttMin = mn; e.ttMax = mx; e.mis = ms; e.first = fi;
      e.doneCyc = cyc + 1 + 48; e.expFail = ef;
      q4.push_back(e);
      start4 = 1'b1; tick(1); start4 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q3.size() != 0 || q4.size() != 0) && n < 200) begin
         tick(1);
         n++;
      end
      check("drain_timeout", 32'(q3.size() + q4.size()), 32'd0);
   endtask

   initial begin
      rst3 = 1'b1; rst4 = 1'b1; start3 = 1'b1; start4 = 1'b1; mode4 = 0;
`ifdef TT_SCAN_EXPECT_EN
      expRef3 = 16'h0067; expRef4 = 16'h55AA;
`endif
      tick(2);
      start3 = 1'b0; start4 = 1'b0;
      // Reset wins over start.
      check("rst_busy3", 32'(busy3), 32'd0);
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_done", 32'({done3, done4}), 32'd0);
      check("rst_tt", 32'({ttMin3, ttMax4}), 32'd0);
      check("rst_vec", 32'({a3, b3, c3, d3, vec4}), 32'd0);
      check("rst_mis", 32'({mis3, first3, mis4, first4}), 32'd0);
      rst3 = 1'b0; rst4 = 1'b0;
      tick(1);

      fork
         forever begin : monitor
            exp_t e;
            @(negedge clk);
            if (done3) begin
               if (q3.size() == 0) check("done3_unexpected", 32'(done3), 32'd0);
               else begin
                  e = q3.pop_front();
                  compareResult("s3", e, ttMin3, ttMax3, mis3, first3);
`ifdef TT_SCAN_EXPECT_EN
                  check("s3_expectFail", 32'(expFail3), 32'(e.expFail));
`endif
               end
            end
            if (done4) begin
               if (q4.size() == 0) check("done4_unexpected", 32'(done4), 32'd0);
               else begin
                  e = q4.pop_front();
                  compareResult("s4", e, ttMin4, ttMax4, mis4, first4);
`ifdef TT_SCAN_EXPECT_EN
                  check("s4_expectFail", 32'(expFail4), 32'(e.expFail));
`endif
               end
            end
         end
      join_none

      // 3-variable function, matching reference.
      startScan3(16'h0067, 16'h0067, 1'b0);
      tick(6);
      check("vec3_idx3", 32'({a3, b3, c3, d3}), 32'b0110);
      check("busy3_mid", 32'(busy3), 32'd1);
      drain();
      tick(3);
      check("hold_ttMin3", 32'(ttMin3), 32'h0067);
      check("idle_busy3", 32'(busy3), 32'd0);
      check("idle_vec3", 32'({a3, b3, c3, d3}), 32'd0);

      // Same scan against a wrong reference.
      startScan3(16'h0067, 16'h0066, 1'b1);
      drain();

      // start during SAMPLE and DONE must be ignored.
      startScan3(16'h0067, 16'h0067, 1'b0);
      tick(1);
      start3 = 1'b1; tick(1); start3 = 1'b0;
      tick(14);
      check("done3_at16", 32'(done3), 32'd1);
      start3 = 1'b1; tick(1); start3 = 1'b0;
      tick(3);
      check("no_restart_busy3", 32'(busy3), 32'd0);
      check("no_restart_q3", 32'(q3.size()), 32'd0);

      // 4-variable scan, flipped max term at idx 5.
      mode4 = 2;
      startScan4(16'h55AA, 16'h558A, 1'b1, 4'd5, 1'b1);
      drain();

      // Forcing 1 where a^d is already 1 gives identical tables.
      mode4 = 1;
      startScan4(16'h55AA, 16'h55AA, 1'b0, 4'd0, 1'b0);
      drain();

      // Reset mid-scan at idx 7: abort, no done.
      mode4 = 0;
      start4 = 1'b1; tick(1); start4 = 1'b0;
      begin
         int n = 0;
         while (vec4 != 4'd7 && n < 200) begin tick(1); n++; end
      end
      check("reach_idx7", 32'(vec4), 32'd7);
      check("partial_ttMin4", 32'(ttMin4 != 16'h0), 32'd1);
      rst4 = 1'b1; tick(1); rst4 = 1'b0;
      check("abort_busy4", 32'(busy4), 32'd0);
      check("abort_ttMin4", 32'(ttMin4), 32'd0);
      check("abort_done4", 32'(done4), 32'd0);
      check("abort_vec4", 32'(vec4), 32'd0);
      tick(60);
      check("abort_idle_busy4", 32'(busy4), 32'd0);

      // Fresh scan after the abort completes normally.
      mode4 = 2;
      startScan4(16'h55AA, 16'h558A, 1'b1, 4'd5, 1'b1);
      drain();
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
